// File: rtl/write_back_pkg.sv
// Shared widths and the write-request record used by the write-back stage.
package write_back_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Two-entry in-order queue holding ALU results that lost the write port to a load.
module wb_fifo
  import write_back_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  push_i,
  input  logic [REG_ADDR_W-1:0] push_rd_i,
  input  logic [XLEN-1:0]       push_data_i,
  input  logic                  pop_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [REG_ADDR_W-1:0] head_rd_o,
  output logic [XLEN-1:0]       head_data_o
);

  wb_req_t    entry_q [2];
  wb_req_t    entry_d [2];
  logic [1:0] count_q, count_d;
  logic [1:0] fill;
  logic       do_pop, do_push;
  wb_req_t    req;

  always_comb begin
    entry_d    = entry_q;
    req.rd     = push_rd_i;
    req.data   = push_data_i;
    do_pop     = pop_i && (count_q != 2'd0);
    do_push    = push_i && ((count_q != 2'd2) || do_pop);
    fill       = count_q - {1'b0, do_pop};
    if (do_pop) entry_d[0] = entry_q[1];
    // Entry 0 is always the head; a push lands in the first slot left free after the pop.
    if (do_push) begin
      if (fill == 2'd0) entry_d[0] = req;
      else              entry_d[1] = req;
    end
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q    <= 2'd0;
      entry_q[0] <= '0;
      entry_q[1] <= '0;
    end else begin
      count_q    <= count_d;
      entry_q[0] <= entry_d[0];
      entry_q[1] <= entry_d[1];
    end
  end

  assign full_o      = (count_q == 2'd2);
  assign empty_o     = (count_q == 2'd0);
  assign head_rd_o   = entry_q[0].rd;
  assign head_data_o = entry_q[0].data;

endmodule

// File: rtl/write_back.sv
// Write-back arbiter (load priority, 2-deep ALU queue) plus busy-bit scoreboard.
// Define WB_FORWARD_EN to add same-cycle forwarding ports and relax the stall.
module write_back
  import write_back_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issueValid,
  input  logic [REG_ADDR_W-1:0] issueRd,
  input  logic                  aluValid,
  input  logic [REG_ADDR_W-1:0] aluRd,
  input  logic [XLEN-1:0]       aluData,
  output logic                  aluReady,
  input  logic                  memValid,
  input  logic [REG_ADDR_W-1:0] memRd,
  input  logic [XLEN-1:0]       memData,
  input  logic [REG_ADDR_W-1:0] readRegister1,
  input  logic [REG_ADDR_W-1:0] readRegister2,
  output logic                  regWrite,
  output logic [REG_ADDR_W-1:0] writeRegister,
  output logic [XLEN-1:0]       writeData,
  output logic                  hazardStall
`ifdef WB_FORWARD_EN
  ,
  output logic                  fwdValid1,
  output logic                  fwdValid2,
  output logic [XLEN-1:0]       fwdData1,
  output logic [XLEN-1:0]       fwdData2
`endif
);

  logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [XLEN-1:0]       head_data;
  logic                  alu_acc, wr_slot;
  wb_req_t               wr_req;

  logic                  regWrite_q, regWrite_d;
  logic [REG_ADDR_W-1:0] writeRegister_q, writeRegister_d;
  logic [XLEN-1:0]       writeData_q, writeData_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d, busy_clr, busy_set;
  logic                  src1_busy, src2_busy;

  wb_fifo u_fifo (
    .clk_i       (clk),
    .reset_i     (reset),
    .push_i      (fifo_push),
    .push_rd_i   (aluRd),
    .push_data_i (aluData),
    .pop_i       (fifo_pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_rd_o   (head_rd),
    .head_data_o (head_data)
  );

  // A full queue can still take a result when its head drains this cycle.
  assign aluReady = !reset && (!fifo_full || !memValid);
  assign alu_acc  = aluValid && aluReady;

  always_comb begin
    fifo_pop  = !memValid && !fifo_empty;
    fifo_push = alu_acc && !(fifo_empty && !memValid);
    wr_slot   = memValid || !fifo_empty || alu_acc;
    if (memValid) begin
      wr_req.rd   = memRd;
      wr_req.data = memData;
    end else if (!fifo_empty) begin
      wr_req.rd   = head_rd;
      wr_req.data = head_data;
    end else begin
      wr_req.rd   = aluRd;
      wr_req.data = aluData;
    end
    regWrite_d      = wr_slot && (wr_req.rd != '0);
    writeRegister_d = wr_slot ? wr_req.rd   : writeRegister_q;
    writeData_d     = wr_slot ? wr_req.data : writeData_q;
  end

`ifdef WB_FORWARD_EN
  assign fwdValid1 = regWrite_q && (writeRegister_q == readRegister1) && (readRegister1 != '0);
  assign fwdValid2 = regWrite_q && (writeRegister_q == readRegister2) && (readRegister2 != '0);
  assign fwdData1  = writeData_q;
  assign fwdData2  = writeData_q;
  // A source being written this cycle is served by the forward path instead of stalling.
  assign src1_busy = busy_q[readRegister1] && !fwdValid1;
  assign src2_busy = busy_q[readRegister2] && !fwdValid2;
`else
  assign src1_busy = busy_q[readRegister1];
  assign src2_busy = busy_q[readRegister2];
`endif

  assign hazardStall = src1_busy || src2_busy || busy_q[issueRd];

  // Set is applied after clear so a new producer of r wins over the retiring one.
  always_comb begin
    busy_clr = '0;
    busy_set = '0;
    if (regWrite_q) busy_clr[writeRegister_q] = 1'b1;
    if (issueValid && (issueRd != '0) && !hazardStall) busy_set[issueRd] = 1'b1;
    busy_d    = (busy_q & ~busy_clr) | busy_set;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regWrite_q      <= 1'b0;
      writeRegister_q <= '0;
      writeData_q     <= '0;
      busy_q          <= '0;
    end else begin
      regWrite_q      <= regWrite_d;
      writeRegister_q <= writeRegister_d;
      writeData_q     <= writeData_d;
      busy_q          <= busy_d;
    end
  end

  assign regWrite      = regWrite_q;
  assign writeRegister = writeRegister_q;
  assign writeData     = writeData_q;

endmodule

// File: doc/write_back.md
WRITE_BACK -- requirements
Module: write_back

Interface
REQ-001 SHALL have one clock and one synchronous, active-high reset; all state updates on rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 issueValid  input  1  decode issues an instruction this cycle; issueRd  input  5  its destination register.
REQ-005 aluValid  input  1 / aluRd  input  5 / aluData  input  32  single-cycle ALU result offered.
REQ-006 aluReady  output  1  ALU result accepted when aluValid and aluReady are both high.
REQ-007 memValid  input  1 / memRd  input  5 / memData  input  32  load response; no backpressure, always accepted.
REQ-008 readRegister1, readRegister2  input  5 each  decode source registers for hazard check.
REQ-009 regWrite  output  1 / writeRegister  output  5 / writeData  output  32  register-file write port, registered.
REQ-010 hazardStall  output  1  decode must hold the current instruction.

Function
REQ-011 Writes SHALL be registered: source accepted in cycle N drives regWrite=1 with its rd/data in cycle N+1, for exactly one cycle.
REQ-012 memValid SHALL have priority: when memValid=1 the load is written; ALU results wait.
REQ-013 Accepted ALU results SHALL enter a 2-entry in-order FIFO; FIFO head is written in any cycle memValid=0.
REQ-014 An ALU result accepted into an empty FIFO with memValid=0 SHALL bypass the FIFO (latency 1, REQ-011).
REQ-015 aluReady SHALL be 1 iff FIFO count < 2, or count = 2 and the head drains this cycle (memValid=0).
REQ-016 memValid=1 for consecutive cycles with full FIFO SHALL hold aluReady=0 with no loss or reordering of ALU data.
REQ-017 Writes with rd=0 SHALL consume a write slot but drive regWrite=0; writeRegister/writeData still update.
REQ-018 Scoreboard: 32 busy bits; issueValid with issueRd!=0 SHALL set busy[issueRd] next cycle; bit 0 never set.
REQ-019 busy[r] SHALL clear in the cycle after regWrite=1 with writeRegister=r.
REQ-020 Simultaneous set and clear of the same r SHALL leave busy[r]=1 (new producer wins).
REQ-021 hazardStall (combinational) SHALL be busy[readRegister1] | busy[readRegister2] | busy[issueRd]; index 0 never stalls.
REQ-022 issueValid while hazardStall=1 SHALL be ignored by the scoreboard.

Reset
REQ-023 reset SHALL clear FIFO, all busy bits, regWrite=0, writeRegister=0, writeData=0; aluReady=0 while reset=1, 1 first cycle after.
REQ-024 reset mid-operation SHALL discard FIFO contents and in-flight writes; no regWrite in the cycle after reset.

Configuration
REQ-025 Macro WB_FORWARD_EN SHALL add outputs fwdValid1, fwdValid2 (1) and fwdData1, fwdData2 (32).
REQ-026 With WB_FORWARD_EN: fwdValidN=1 and fwdDataN=writeData when regWrite=1 and writeRegister=readRegisterN!=0; hazardStall omits a source whose matching busy bit clears this cycle.
REQ-027 Without WB_FORWARD_EN: no forward ports; hazardStall exactly per REQ-021.

Structure
REQ-028 Shared package SHALL hold REG_ADDR_W=5, XLEN=32, NUM_REGS=32 and the write-request struct {rd, data}.
REQ-029 The 2-entry FIFO SHALL be a sub-module wb_fifo (push/pop/full/empty, head data); scoreboard stays in write_back.

Verification
REQ-030 ALU rd=5 data=0x11 at cycle 1, FIFO empty, memValid=0 -> cycle 2 regWrite=1, writeRegister=5, writeData=0x11.
REQ-031 memValid rd=3 data=0xAA and aluValid rd=4 data=0xBB same cycle -> rd3 written next cycle, rd4 the cycle after.
REQ-032 memValid held 4 cycles, ALU offering each cycle -> aluReady falls after 2 accepts; three results then written in order.
REQ-033 issue rd=7; readRegister1=7 -> hazardStall=1 until the cycle after rd7 writeback, then 0.
REQ-034 issue rd=0, ALU result rd=0 -> hazardStall never asserts; regWrite stays 0.
REQ-035 reset asserted with 2 FIFO entries and busy[9]=1 -> after reset no regWrite, hazardStall=0 for readRegister1=9, aluReady=1.
